cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multicycle control FSM that steps the core through fetch, decode, execute, memory and writeback. It issues the instruction-memory and data-memory handshakes, and pulses the `enable` input of the decoder and the enables of the downstream execute and writeback stages. It also detects EBREAK (halt), enforces a memory-response timeout and counts retired instructions.

## Interface
- `COUNT_WIDTH`, default 32: width of the retired-instruction counter.
- `MEM_TIMEOUT`, default 16: maximum number of cycles to wait for `imem_ack`/`dmem_ack` before faulting. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin execution; sampled only in IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete; `instr` valid this cycle.
- `instr`  in  32  fetched instruction word (instruction_t).
- `decode_enable`  out  1  one-cycle pulse to the decoder `enable`.
- `exec_enable`  out  1  one-cycle pulse to the ALU/execute stage.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store); valid only with `dmem_req`.
- `dmem_ack`  in  1  data access complete.
- `wb_enable`  out  1  register-bank write strobe.
- `pc_update`  out  1  advance/redirect the PC; one pulse per retired non-EBREAK instruction.
- `halted`  out  1  core stopped on EBREAK.
- `bus_error`  out  1  memory timeout fault; sticky.
- `retired`  out  COUNT_WIDTH  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT, ERROR.
- Outputs are Moore, decoded from the registered state only.
- **Opcode latch:** `instr_q` captures `instr` on the cycle FETCH sees `imem_ack`. The decoder receives `instr` through the fetch register, which the fetch logic holds stable.
- **Classification** on `instr_q`:
  - load: `[6:0]`=0000011.
  - store: `[6:0]`=0100011.
  - branch: `[6:0]`=1100011.
  - EBREAK: `instr_q`==32'h00100073.
  - Everything else is treated as register-writing.
- **IDLE:** all outputs 0. `start`=1 → FETCH.
- **FETCH:** `imem_req`=1.
  - `imem_ack` → DECODE.
  - Otherwise the wait counter increments. When `MEM_TIMEOUT` consecutive cycles pass with no ack → ERROR.
- **DECODE:** `decode_enable`=1 for exactly one cycle.
  - EBREAK → HALT, and `retired` increments on this transition.
  - Otherwise → EXECUTE.
- **EXECUTE:** `exec_enable`=1 for one cycle.
  - load/store → MEM.
  - Otherwise → WB.
- **MEM:** `dmem_req`=1; `dmem_we`=1 iff store.
  - `dmem_ack` → WB.
  - Timeout rule is the same as FETCH → ERROR.
- **WB:** `pc_update`=1, `retired` increments, then → FETCH.
  - `wb_enable`=1 unless store or branch.
- **HALT:** `halted`=1, all other strobes 0. Exit only by reset.
- **ERROR:** `bus_error`=1, all strobes 0. Exit only by reset.
- **Wait counter:** width `$clog2(MEM_TIMEOUT+1)`. Cleared on every entry to FETCH or MEM. An ack on the `MEM_TIMEOUT`-th waiting cycle is accepted; ack takes priority over timeout.
- **`retired` counter:** wraps modulo 2^COUNT_WIDTH with no saturation or flag.
- **Ignored inputs:** `start` outside IDLE; `imem_ack` outside FETCH; `dmem_ack` outside MEM.

## Timing
- **Reset:** asserting `rst` forces IDLE, clears `retired`, `instr_q` and the wait counter, and drives all outputs to 0 immediately, without waiting for `clk`. This applies mid-transaction too: an outstanding `imem_req`/`dmem_req` drops the same instant and a late ack is ignored. The first posedge after deassertion still samples IDLE.
- **Latency from FETCH entry, ack in the first cycle:**
  - ALU/branch: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - load/store: 5 cycles.
  - EBREAK: `halted` rises 2 cycles after FETCH entry.
  - Each cycle of ack delay adds 1.
- `start` in cycle N → `imem_req` high in cycle N+1.
- `pc_update` and `wb_enable` are coincident and last 1 cycle. The `retired` increment is visible the cycle after WB.
- Back-to-back instructions: WB is followed directly by FETCH with no idle cycle.

## Test plan
- **ADD back-to-back:** reset, `start`, ADD (32'h002081B3) with immediate ack, repeated 3×. Required: each instruction follows FETCH→DECODE→EXECUTE→WB with one `decode_enable`, `exec_enable`, `wb_enable` and `pc_update` pulse; `retired`=3 after the third WB.
- **Store then branch:** SW (32'h0020A023) with `dmem_ack` 3 cycles late → `dmem_req` and `dmem_we` high for 4 cycles, `wb_enable`=0, `pc_update`=1. Then BEQ → `wb_enable`=0, no `dmem_req`.
- **Load timeout boundary:**
  - `MEM_TIMEOUT`=4, `dmem_ack` on the 4th waiting cycle → reaches WB.
  - No ack → ERROR after 4 cycles, `bus_error`=1 sticky, `dmem_req`=0.
- **EBREAK:** instruction 32'h00100073 → `halted`=1 two cycles after FETCH entry, `retired` incremented, no `exec_enable`/`pc_update`. Further `start`/acks have no effect.
- **Async reset mid-MEM:** `rst` asserted between edges while `dmem_req`=1 → all outputs 0 before the next edge; `retired`=0; the core resumes only on a new `start`.
- **Counter wrap:** `COUNT_WIDTH`=3, 9 ALU instructions → `retired` reads 1.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle fetch/decode/execute/mem/writeback control FSM
module cpu_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   imem_req,
  input  logic                   imem_ack,
  input  logic [31:0]            instr,
  output logic                   decode_enable,
  output logic                   exec_enable,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  output logic                   wb_enable,
  output logic                   pc_update,
  output logic                   halted,
  output logic                   bus_error,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  state_t                 state, state_nxt;
  logic [31:0]            instr_q;
  logic [WW-1:0]          wait_cnt, wait_nxt;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                   retire;
  logic                   is_load, is_store, is_branch, is_ebreak;

  assign is_load   = (instr_q[6:0] == 7'b0000011);
  assign is_store  = (instr_q[6:0] == 7'b0100011);
  assign is_branch = (instr_q[6:0] == 7'b1100011);
  assign is_ebreak = (instr_q == 32'h0010_0073);
  assign retired   = retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      instr_q   <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_FETCH && imem_ack) instr_q <= instr;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // Outputs depend only on the registered state (and the latched opcode).
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    retire        = 1'b0;
    imem_req      = 1'b0;
    decode_enable = 1'b0;
    exec_enable   = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    wb_enable     = 1'b0;
    pc_update     = 1'b0;
    halted        = 1'b0;
    bus_error     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          wait_nxt  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)                   state_nxt = S_DECODE;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_ERROR;
        else                            wait_nxt  = wait_cnt + 1'b1;
      end
      S_DECODE: begin
        decode_enable = 1'b1;
        if (is_ebreak) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        exec_enable = 1'b1;
        if (is_load || is_store) begin
          state_nxt = S_MEM;
          wait_nxt  = '0;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack)                   state_nxt = S_WB;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_ERROR;
        else                            wait_nxt  = wait_cnt + 1'b1;
      end
      S_WB: begin
        pc_update = 1'b1;
        wb_enable = !(is_store || is_branch);
        retire    = 1'b1;
        state_nxt = S_FETCH;
        wait_nxt  = '0;
      end
      S_HALT:  halted    = 1'b1;
      S_ERROR: bus_error = 1'b1;
      default: state_nxt = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized directed bench for cpu_sequencer against a cycle-schedule model
module tb_cpu_sequencer;
  localparam int CW = 3;
  localparam int T  = 4;

  localparam logic [8:0] E_IDLE  = 9'b000000000;
  localparam logic [8:0] E_FETCH = 9'b100000000;
  localparam logic [8:0] E_DEC   = 9'b010000000;
  localparam logic [8:0] E_EXE   = 9'b001000000;
  localparam logic [8:0] E_HALT  = 9'b000000010;
  localparam logic [8:0] E_ERR   = 9'b000000001;

  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_SW     = 32'h0020A023;
  localparam logic [31:0] I_BEQ    = 32'h00208063;
  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_EBREAK = 32'h00100073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] instr = '0;
  logic imem_req, decode_enable, exec_enable, dmem_req, dmem_we;
  logic wb_enable, pc_update, halted, bus_error;
  logic [CW-1:0] retired;
  logic [8:0] obs;

  int total = 0;
  int bad = 0;
  int model_ret = 0;

  cpu_sequencer #(.COUNT_WIDTH(CW), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .decode_enable(decode_enable), .exec_enable(exec_enable),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .wb_enable(wb_enable), .pc_update(pc_update),
    .halted(halted), .bus_error(bus_error), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, decode_enable, exec_enable, dmem_req, dmem_we,
                wb_enable, pc_update, halted, bus_error};

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [CW-1:0] exp_r;
    exp_r = model_ret[CW-1:0];
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s outputs=%b expected=%b", tag, obs, exp);
    end
    total++;
    assert (retired === exp_r) else begin
      bad++;
      $error("FAIL %s_retired retired=%0d expected=%0d", tag, retired, exp_r);
    end
  endtask

  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    start    = 1'($urandom);
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
    instr    = $urandom;
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    model_ret = 0;
    #1;
    chk(tag, E_IDLE);
    noise();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic go();
    noise();
    start = 1'b1;
    cyc("idle_start", E_IDLE);
  endtask

  task automatic idle_hold(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      start = 1'b0;
      cyc("idle_hold", E_IDLE);
    end
  endtask

  task automatic stuck(input string tag, input logic [8:0] exp, input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      cyc(tag, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] r;
    r = $urandom;
    case (cls)
      0: return {r[31:7], 7'b0000011};
      1: return {r[31:7], 7'b0100011};
      2: return {r[31:7], 7'b1100011};
      default: return {r[31:7], r[0] ? 7'b0110011 : 7'b0010011};
    endcase
  endfunction

  // fd/md: ack on waiting cycle fd+1 / md+1; a value >= T means no ack at all.
  // rst_at >= 0 asserts reset asynchronously during that MEM waiting cycle.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md, input int rst_at);
    logic [6:0] op;
    logic ld, st, br;
    op = ins[6:0];
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    br = (op == 7'b1100011);
    for (int i = 0; i < T; i++) begin
      noise();
      imem_ack = (i == fd);
      if (i == fd) instr = ins;
      cyc("fetch", E_FETCH);
      if (i == fd) break;
    end
    if (fd >= T) return;
    noise();
    cyc("decode", E_DEC);
    if (ins == I_EBREAK) begin
      model_ret++;
      return;
    end
    noise();
    cyc("execute", E_EXE);
    if (ld || st) begin
      for (int j = 0; j < T; j++) begin
        noise();
        dmem_ack = (j == md);
        if (j == rst_at) begin
          @(negedge clk);
          chk("mem_before_rst", {3'b000, 1'b1, st, 4'b0000});
          #2;
          async_reset("async_rst_mid_mem");
          return;
        end
        cyc("mem", {3'b000, 1'b1, st, 4'b0000});
        if (j == md) break;
      end
      if (md >= T) return;
    end
    noise();
    cyc("wb", {5'b00000, !(st || br), 1'b1, 2'b00});
    model_ret++;
  endtask

  initial begin
    #3;
    chk("reset_state", E_IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_hold(3);

    // three back-to-back ADDs with immediate ack
    go();
    for (int k = 0; k < 3; k++) run_instr(I_ADD, 0, 0, -1);
    total++;
    assert (retired === CW'(3)) else begin
      bad++;
      $error("FAIL add_x3_retired retired=%0d expected=3", retired);
    end

    // store with late ack, then branch
    run_instr(I_SW, 0, 3, -1);
    run_instr(I_BEQ, 0, 0, -1);

    // load accepted on the last permitted waiting cycle, fetch also late
    run_instr(I_LW, T - 1, T - 1, -1);

    // randomized mix with random ack delays inside the timeout window
    for (int k = 0; k < 24; k++)
      run_instr(rand_instr($urandom_range(0, 3)), $urandom_range(0, T - 1),
                $urandom_range(0, T - 1), -1);

    // counter wrap: nine ALU instructions from reset -> 9 mod 8
    async_reset("rst_before_wrap");
    idle_hold(1);
    go();
    for (int k = 0; k < 9; k++) run_instr(rand_instr(3), $urandom_range(0, 1), 0, -1);
    total++;
    assert (retired === CW'(1)) else begin
      bad++;
      $error("FAIL wrap_retired retired=%0d expected=1", retired);
    end

    // load with no data ack -> sticky bus error
    run_instr(I_LW, 0, T, -1);
    stuck("dmem_timeout_err", E_ERR, 5);

    // fetch with no ack -> bus error
    async_reset("rst_after_err");
    go();
    run_instr(I_ADD, T, 0, -1);
    stuck("imem_timeout_err", E_ERR, 4);

    // EBREAK after one ALU instruction
    async_reset("rst_before_ebreak");
    go();
    run_instr(I_ADD, 0, 0, -1);
    run_instr(I_EBREAK, 0, 0, -1);
    stuck("halt_hold", E_HALT, 5);

    // asynchronous reset while a load waits on the data bus
    async_reset("rst_before_mid_mem");
    go();
    run_instr(I_ADD, 0, 0, -1);
    run_instr(I_LW, 1, T, 2);
    idle_hold(4);
    go();
    run_instr(I_SW, 0, 1, -1);
    run_instr(rand_instr(3), 2, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
